// File: rtl/modn_counter.sv
// ---------------------------------------------------------------------------
// modn_counter
//
// Parametrised modulo-N up/down counter for the timekeeping datapath
// (sec -> min -> hour). It steps on qualified ticks, supports synchronous
// clear and range-checked load, and produces same-cycle carry/borrow strobes
// so that chained instances step on the same clock edge.
//
// Parameters:
//   MODULUS    count range 0..MODULUS-1 (2 .. 2^WIDTH)
//   WIDTH      count width
//   RESET_VAL  count value after reset (< MODULUS)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable
//   tick      in   single-cycle step strobe
//   up        in   1 = increment, 0 = decrement (taken per step)
//   clear     in   synchronous clear to 0 (highest priority)
//   load      in   synchronous load of load_val
//   load_val  in   value to load, WIDTH bits
//   count     out  registered count value
//   carry     out  combinational: stepping up from MODULUS-1 this cycle
//   borrow    out  combinational: stepping down from 0 this cycle
//   load_err  out  registered one-cycle pulse after an out-of-range load
//   bcd_tens  out  registered tens digit of count  (MODN_BCD_OUT_EN only)
//   bcd_ones  out  registered ones digit of count  (MODN_BCD_OUT_EN only)
//
// Optional feature macro: MODN_BCD_OUT_EN adds the BCD digit outputs,
// registered from the next-state count so they stay aligned with count.
// ---------------------------------------------------------------------------
module modn_counter #(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 6,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
`ifdef MODN_BCD_OUT_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`endif
);

    // Elaboration-time parameter sanity checks.
    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("modn_counter: MODULUS must lie in 2 .. 2^WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
            $error("modn_counter: RESET_VAL must be below MODULUS");
        end
`ifdef MODN_BCD_OUT_EN
        if (MODULUS > 100) begin : g_bad_bcd_modulus
            $error("modn_counter: BCD outputs need MODULUS <= 100");
        end
`endif
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
    // Compared at WIDTH+1 bits so MODULUS == 2^WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, MAX_VAL};

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             load_err_reg;
    logic             load_err_next;

    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             load_ok;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;

    assign count_ext = {1'b0, count_reg};
    assign load_ext  = {1'b0, load_val};

    // clear and load both pre-empt a step, which also silences carry/borrow.
    assign step    = en & tick & ~clear & ~load;
    assign at_max  = (count_ext == MAX_EXT);
    assign at_zero = (count_reg == '0);
    assign load_ok = (load_ext < MOD_EXT);

    assign carry   = step &  up & at_max;
    assign borrow  = step & ~up & at_zero;

    // Wrap is selected explicitly at the range ends, so the +/-1 below never
    // overflows the WIDTH-bit register for any legal MODULUS.
    always_comb begin
        count_next    = count_reg;
        load_err_next = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            if (load_ok) begin
                count_next = load_val;
            end else begin
                count_next    = MAX_VAL;
                load_err_next = 1'b1;
            end
        end else if (step) begin
            if (up) begin
                count_next = at_max ? '0 : count_reg + WIDTH'(1);
            end else begin
                count_next = at_zero ? MAX_VAL : count_reg - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= RST_VAL;
            load_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            load_err_reg <= load_err_next;
        end
    end

    assign count    = count_reg;
    assign load_err = load_err_reg;

`ifdef MODN_BCD_OUT_EN
    localparam logic [3:0] RST_TENS = 4'(RESET_VAL / 10);
    localparam logic [3:0] RST_ONES = 4'(RESET_VAL % 10);

    logic [3:0]  bcd_tens_reg;
    logic [3:0]  bcd_ones_reg;
    logic [3:0]  bcd_tens_next;
    logic [3:0]  bcd_ones_next;
    int unsigned count_next_int;

    // Digits derived from the next-state count keep them aligned with count.
    always_comb begin
        count_next_int = 32'(count_next);
        bcd_tens_next  = 4'(count_next_int / 10);
        bcd_ones_next  = 4'(count_next_int % 10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_tens_reg <= RST_TENS;
            bcd_ones_reg <= RST_ONES;
        end else begin
            bcd_tens_reg <= bcd_tens_next;
            bcd_ones_reg <= bcd_ones_next;
        end
    end

    assign bcd_tens = bcd_tens_reg;
    assign bcd_ones = bcd_ones_reg;
`endif

endmodule

// File: tb/tb_modn_counter.sv
// ---------------------------------------------------------------------------
// tb_modn_counter
//
// Self-checking bench for modn_counter (MODULUS=60, WIDTH=6, RESET_VAL=0).
// A second instance is chained on the first one's carry. Directed vectors
// with hand-computed expectations are applied from a table, followed by
// hand-written sequences for asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_modn_counter;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, tick, up, clear, load;
    logic [5:0] load_val;
    logic [5:0] count;
    logic       carry, borrow, load_err;
    logic [5:0] chain_count;
    logic       chain_carry, chain_borrow, chain_load_err;
`ifdef MODN_BCD_OUT_EN
    logic [3:0] bcd_tens, bcd_ones;
    logic [3:0] chain_bcd_tens, chain_bcd_ones;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modn_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .tick     (tick),
        .up       (up),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .borrow   (borrow),
        .load_err (load_err)
`ifdef MODN_BCD_OUT_EN
        ,
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones)
`endif
    );

    modn_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0)) u_chain (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .tick     (carry),
        .up       (1'b1),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val (6'd0),
        .count    (chain_count),
        .carry    (chain_carry),
        .borrow   (chain_borrow),
        .load_err (chain_load_err)
`ifdef MODN_BCD_OUT_EN
        ,
        .bcd_tens (chain_bcd_tens),
        .bcd_ones (chain_bcd_ones)
`endif
    );

    typedef struct {
        logic       en, tick, up, clear, load;
        logic [5:0] load_val;
        logic [5:0] exp_count;
        logic       exp_carry, exp_borrow, exp_err;
        logic [5:0] exp_chain;
        string      name;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic t, input logic u,
                                input logic c, input logic l, input logic [5:0] lv,
                                input logic [5:0] ec, input logic ecy, input logic ebw,
                                input logic eer, input logic [5:0] ech, input string nm);
        vec_t v;
        v.en = e; v.tick = t; v.up = u; v.clear = c; v.load = l; v.load_val = lv;
        v.exp_count = ec; v.exp_carry = ecy; v.exp_borrow = ebw; v.exp_err = eer;
        v.exp_chain = ech; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bcd(input string name, input logic [5:0] exp_count);
`ifdef MODN_BCD_OUT_EN
        chk({name, "_bcd_tens"}, 32'(bcd_tens), 32'(exp_count / 6'd10));
        chk({name, "_bcd_ones"}, 32'(bcd_ones), 32'(exp_count % 6'd10));
`else
        if (exp_count === 6'bx) $display("note %s: unknown expected count", name);
`endif
    endtask

    task automatic set_idle();
        en = 1'b0; tick = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 6'd0;
    endtask

    // Called just after a rising edge: drive inputs, check the combinational
    // strobes, then check the registered state after the next edge.
    task automatic apply(input vec_t v);
        en = v.en; tick = v.tick; up = v.up; clear = v.clear; load = v.load;
        load_val = v.load_val;
        #1;
        chk({v.name, "_carry"},  32'(carry),  32'(v.exp_carry));
        chk({v.name, "_borrow"}, 32'(borrow), 32'(v.exp_borrow));
        @(posedge clk);
        #1;
        chk({v.name, "_count"},    32'(count),       32'(v.exp_count));
        chk({v.name, "_load_err"}, 32'(load_err),    32'(v.exp_err));
        chk({v.name, "_chain"},    32'(chain_count), 32'(v.exp_chain));
        check_bcd(v.name, v.exp_count);
        $display("txn %-12s en=%0d tick=%0d up=%0d clr=%0d ld=%0d lv=%0d -> count=%0d carry=%0d borrow=%0d err=%0d chain=%0d",
                 v.name, v.en, v.tick, v.up, v.clear, v.load, v.load_val,
                 count, v.exp_carry, v.exp_borrow, load_err, chain_count);
    endtask

    vec_t vecs[21];

    initial begin
        // Table continues from count=0, chain=1 after the 60-tick run.
        //              en tick up clr ld  lv      count  cy bw er chain name
        vecs[0]  = mk(T, T, F, F, F, 6'd0,  6'd59, F, T, F, 6'd1, "down_wrap");
        vecs[1]  = mk(T, T, T, F, F, 6'd0,  6'd0,  T, F, F, 6'd2, "up_wrap");
        vecs[2]  = mk(T, T, T, F, T, 6'd42, 6'd42, F, F, F, 6'd2, "load42_tick");
        vecs[3]  = mk(T, T, T, F, T, 6'd63, 6'd59, F, F, T, 6'd2, "load63_bad");
        vecs[4]  = mk(T, T, T, F, T, 6'd10, 6'd10, F, F, F, 6'd2, "load_at_max");
        vecs[5]  = mk(F, F, T, F, T, 6'd60, 6'd59, F, F, T, 6'd2, "load60_bad");
        vecs[6]  = mk(F, F, T, F, F, 6'd0,  6'd59, F, F, F, 6'd2, "err_drop");
        vecs[7]  = mk(F, F, T, F, T, 6'd59, 6'd59, F, F, F, 6'd2, "load59_ok");
        vecs[8]  = mk(F, F, T, F, T, 6'd30, 6'd30, F, F, F, 6'd2, "load30");
        vecs[9]  = mk(T, T, T, T, T, 6'd63, 6'd0,  F, F, F, 6'd2, "clr_and_ld");
        vecs[10] = mk(F, T, T, F, F, 6'd0,  6'd0,  F, F, F, 6'd2, "en0_up");
        vecs[11] = mk(F, T, F, F, F, 6'd0,  6'd0,  F, F, F, 6'd2, "en0_down");
        vecs[12] = mk(T, T, F, T, F, 6'd0,  6'd0,  F, F, F, 6'd2, "clr_down");
        vecs[13] = mk(T, T, T, F, F, 6'd0,  6'd1,  F, F, F, 6'd2, "held_up1");
        vecs[14] = mk(T, T, T, F, F, 6'd0,  6'd2,  F, F, F, 6'd2, "held_up2");
        vecs[15] = mk(T, T, F, F, F, 6'd0,  6'd1,  F, F, F, 6'd2, "dir_flip");
        vecs[16] = mk(F, F, T, F, T, 6'd47, 6'd47, F, F, F, 6'd2, "load47");
        vecs[17] = mk(F, F, T, F, T, 6'd59, 6'd59, F, F, F, 6'd2, "load59");
        vecs[18] = mk(T, T, T, F, F, 6'd0,  6'd0,  T, F, F, 6'd3, "carry_chain");
        vecs[19] = mk(T, T, F, F, T, 6'd5,  6'd5,  F, F, F, 6'd3, "ld_no_borrow");
        vecs[20] = mk(F, F, T, F, F, 6'd0,  6'd5,  F, F, F, 6'd3, "hold");

        // Reset state.
        set_idle();
        rst_n = 1'b0;
        #12;
        chk("rst_count",    32'(count),       32'd0);
        chk("rst_load_err", 32'(load_err),    32'd0);
        chk("rst_carry",    32'(carry),       32'd0);
        chk("rst_borrow",   32'(borrow),      32'd0);
        chk("rst_chain",    32'(chain_count), 32'd0);
        check_bcd("rst", 6'd0);
        $display("txn reset         count=%0d load_err=%0d", count, load_err);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 59 up-ticks from 0 with no carry, then the wrapping tick.
        for (int i = 0; i < 59; i++) begin
            apply(mk(T, T, T, F, F, 6'd0, 6'(i + 1), F, F, F, 6'd0, "count_up"));
        end
        apply(mk(T, T, T, F, F, 6'd0, 6'd0, T, F, F, 6'd1, "first_carry"));

        for (int i = 0; i < 21; i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset in the middle of a cycle at count=17.
        apply(mk(F, F, T, F, T, 6'd17, 6'd17, F, F, F, 6'd3, "load17"));
        en = 1'b1; tick = 1'b1; up = 1'b1; load = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count),       32'd0);
        chk("async_rst_chain", 32'(chain_count), 32'd0);
        check_bcd("async_rst", 6'd0);
        $display("txn async_rst17   count=%0d chain=%0d", count, chain_count);
        @(posedge clk);
        #1;
        chk("rst_held_count", 32'(count), 32'd0);
        rst_n = 1'b1;

        // Reset killing an in-flight carry at count=59.
        apply(mk(F, F, T, F, T, 6'd59, 6'd59, F, F, F, 6'd0, "load59_rst"));
        en = 1'b1; tick = 1'b1; up = 1'b1; load = 1'b0;
        #1;
        chk("inflight_carry", 32'(carry), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("killed_carry",  32'(carry),       32'd0);
        chk("killed_count",  32'(count),       32'd0);
        chk("killed_chain",  32'(chain_count), 32'd0);
        $display("txn rst_carry     count=%0d carry=%0d", count, carry);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // The first edge after release honours the step.
        apply(mk(T, T, T, F, F, 6'd0, 6'd1, F, F, F, 6'd0, "post_rst_step"));

        set_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
